// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the fully-connected layer:
// Q-format constants, data/accumulator types and the saturating adder.
package nn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int INT_WIDTH  = 4;
    localparam int FRAC_WIDTH = DATA_WIDTH - INT_WIDTH - 1;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] data_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Signed add that clamps to ACC_MAX / ACC_MIN instead of wrapping.
    // Overflow only happens when both operands share a sign and the
    // result's sign differs from it.
    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        acc_t s;
        s = a + b;
        if ((a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1])) begin
            s = a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
        return s;
    endfunction

endpackage

// File: rtl/weight_mem.sv
// Per-neuron weight store: one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module weight_mem #(
    parameter int depth     = 784,
    parameter int width     = 16,
    parameter int addrWidth = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [addrWidth-1:0] waddr,
    input  logic [width-1:0]     wdata,
    input  logic [addrWidth-1:0] raddr,
    output logic [width-1:0]     rdata
);

    logic [width-1:0] mem [depth];

    // Write port and registered read port; a read in the same cycle as a
    // write to the same address returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate stage of the fully-connected layer.
// Pipeline: S1 weight read + x register, S2 full-precision product,
// S3 accumulate, then bias add and a one-cycle sum_valid pulse.
// Optional feature macro NEURON_ACC_SAT_EN: saturating accumulate and bias
// add; without it both adds wrap in two's complement.
module neuron_mac import nn_pkg::*; #(
    parameter int dataWidth = DATA_WIDTH,
    parameter int intWidth  = INT_WIDTH,
    parameter int numInputs = 784,
    parameter int addrWidth = (numInputs > 1) ? $clog2(numInputs) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   x_valid,
    input  logic [dataWidth-1:0]   x_in,
    input  logic                   w_we,
    input  logic [addrWidth-1:0]   w_addr,
    input  logic [dataWidth-1:0]   w_data,
    input  logic                   b_we,
    input  logic [2*dataWidth-1:0] b_data,
    output logic                   busy,
    output logic                   sum_valid,
    output logic [2*dataWidth-1:0] sum_out
);

    localparam logic [addrWidth-1:0] LAST_IDX = addrWidth'(numInputs - 1);

    // The arithmetic types come from the shared package, so the instance
    // format has to match it.
    generate
        if (dataWidth != DATA_WIDTH || intWidth != INT_WIDTH || numInputs < 1) begin : g_cfg_check
            $error("neuron_mac: format must match nn_pkg and numInputs must be >= 1");
        end
    endgenerate

    function automatic acc_t add(input acc_t a, input acc_t b);
`ifdef NEURON_ACC_SAT_EN
        return sat_add(a, b);
`else
        return a + b;
`endif
    endfunction

    logic [addrWidth-1:0] cnt_reg;
    logic                 v1_reg, first1_reg, last1_reg;
    data_t                x1_reg;
    data_t                w_rd;
    logic                 v2_reg, first2_reg, last2_reg;
    acc_t                 p2_reg;
    logic                 v3_reg, last3_reg;
    acc_t                 acc_reg;
    acc_t                 bias_reg;
    acc_t                 sum_reg;
    logic                 sum_valid_reg;
    logic                 w_we_ok;

    assign busy      = (cnt_reg != '0) | v1_reg | v2_reg | v3_reg | sum_valid_reg;
    assign w_we_ok   = w_we & ~busy;
    assign sum_valid = sum_valid_reg;
    assign sum_out   = sum_reg;

    weight_mem #(
        .depth     (numInputs),
        .width     (dataWidth),
        .addrWidth (addrWidth)
    ) u_weight_mem (
        .clk   (clk),
        .we    (w_we_ok),
        .waddr (w_addr),
        .wdata (w_data),
        .raddr (cnt_reg),
        .rdata (w_rd)
    );

    // Input counter: position within the frame, doubles as weight read address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (x_valid) begin
            cnt_reg <= (cnt_reg == LAST_IDX) ? '0 : cnt_reg + 1'b1;
        end
    end

    // S1/S2 control: valid bits and first/last tags travel with the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg     <= 1'b0;
            first1_reg <= 1'b0;
            last1_reg  <= 1'b0;
            v2_reg     <= 1'b0;
            first2_reg <= 1'b0;
            last2_reg  <= 1'b0;
        end else begin
            v1_reg     <= x_valid;
            first1_reg <= (cnt_reg == '0);
            last1_reg  <= (cnt_reg == LAST_IDX);
            v2_reg     <= v1_reg;
            first2_reg <= first1_reg;
            last2_reg  <= last1_reg;
        end
    end

    // S1/S2 datapath: registered activation, then the full-width signed product.
    always_ff @(posedge clk) begin
        x1_reg <= x_in;
        p2_reg <= acc_t'(x1_reg) * acc_t'(w_rd);
    end

    // S3: a first-tagged product restarts the sum, so frames need no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            v3_reg    <= 1'b0;
            last3_reg <= 1'b0;
        end else begin
            v3_reg    <= v2_reg;
            last3_reg <= v2_reg & last2_reg;
            if (v2_reg) begin
                acc_reg <= first2_reg ? p2_reg : add(acc_reg, p2_reg);
            end
        end
    end

    // Output stage: bias add once the last product is in; sum_out holds between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            sum_valid_reg <= v3_reg & last3_reg;
            if (v3_reg && last3_reg) begin
                sum_reg <= add(acc_reg, bias_reg);
            end
        end
    end

    // Bias register: loadable only while the neuron is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bias_reg <= '0;
        end else if (b_we && !busy) begin
            bias_reg <= acc_t'(b_data);
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac (numInputs = 4): a frame-level model
// predicts every output cycle; directed scenarios pin known sums.
module tb_neuron_mac;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              x_valid;
    logic [DW-1:0]     x_in;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_data;
    logic              b_we;
    logic [2*DW-1:0]   b_data;
    logic              busy;
    logic              sum_valid;
    logic [2*DW-1:0]   sum_out;

    always #5 clk = ~clk;

    neuron_mac #(.numInputs(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_valid   (x_valid),
        .x_in      (x_in),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_we      (b_we),
        .b_data    (b_data),
        .busy      (busy),
        .sum_valid (sum_valid),
        .sum_out   (sum_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     t;
        longint v;
    } exp_t;

    int      n = 0;          // index of the current clock cycle
    int      m_cnt = 0;      // inputs accepted in the current frame
    bit [2:0] m_hist = '0;   // x accepted 1, 2, 3 cycles ago
    longint  m_acc = 0;
    longint  m_bias = 0;
    int      m_w [N];
    exp_t    exp_q [$];
    bit      cur_valid = 0;
    longint  last_sum = 0;
    bit      model_on = 0;

    function automatic longint addm(input longint a, input longint b);
        longint s;
        logic signed [31:0] t;
        s = a + b;
`ifdef NEURON_ACC_SAT_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
        t = s[31:0];
        s = t;
`endif
        return s;
    endfunction

    function automatic bit model_busy();
        return (m_cnt != 0) || (m_hist != 3'b000) || cur_valid;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) m_w[i] = 0;
        forever begin
            @(posedge clk);
            begin
                bit busy_now;
                longint p;
                busy_now = model_busy();
                if (!rst_n) begin
                    m_cnt  = 0;
                    m_hist = '0;
                    m_bias = 0;
                    exp_q.delete();
                    last_sum = 0;
                end else begin
                    if (x_valid) begin
                        p = longint'($signed(x_in)) * longint'(m_w[m_cnt]);
                        m_acc = (m_cnt == 0) ? p : addm(m_acc, p);
                        if (m_cnt == N - 1) exp_q.push_back('{n + 4, addm(m_acc, m_bias)});
                        m_cnt = (m_cnt + 1) % N;
                    end
                    if (w_we && !busy_now) m_w[w_addr] = int'($signed(w_data));
                    if (b_we && !busy_now) m_bias = longint'($signed(b_data));
                    m_hist = {m_hist[1:0], x_valid};
                end
                n++;
                cur_valid = 0;
                if (exp_q.size() > 0 && exp_q[0].t == n) begin
                    cur_valid = 1;
                    last_sum  = exp_q[0].v;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Compare process: every cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("sum_valid", {63'd0, sum_valid}, {63'd0, cur_valid});
                check("sum_out", $signed(sum_out), last_sum);
                check("busy", {63'd0, busy}, {63'd0, model_busy()});
            end
        end
    end

    // Capture of every sum pulse for the literal checks.
    logic signed [31:0] got_q [$];
    int                 got_t [$];
    int                 last_x = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (sum_valid === 1'b1) begin
                got_q.push_back($signed(sum_out));
                got_t.push_back(n);
                $display("sum cycle %0d value %0d", n, $signed(sum_out));
            end
        end
    end

    // ---------------- driver ----------------
    int fx [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int a, input int d);
        w_we = 1; w_addr = AW'(a); w_data = DW'(d);
        tick();
        w_we = 0;
    endtask

    task automatic write_b(input longint d);
        b_we = 1; b_data = 32'(d);
        tick();
        b_we = 0;
    endtask

    task automatic set_all_w(input int d);
        for (int i = 0; i < N; i++) write_w(i, d);
    endtask

    task automatic fill_x(input int d);
        for (int i = 0; i < N; i++) fx[i] = d;
    endtask

    // abort_at >= 0 pulses reset just before that input index.
    task automatic send_frame(input int gap_max, input int abort_at);
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                rst_n = 0;
                tick();
                rst_n = 1;
                return;
            end
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            x_valid = 1;
            x_in    = DW'(fx[i]);
            last_x  = n;
            tick();
            x_valid = 0;
        end
    endtask

    task automatic drain();
        repeat (7) tick();
    endtask

    task automatic get_sum(output logic signed [31:0] v, output int t);
        int waited = 0;
        while (got_q.size() == 0 && waited < 60) begin
            tick();
            waited++;
        end
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sum_timeout: got no sum_valid within %0d cycles, required one", waited);
            v = 'x;
            t = -1;
        end else begin
            v = got_q.pop_front();
            t = got_t.pop_front();
        end
    endtask

    logic signed [31:0] v, v_ref, e;
    int t;

    initial begin
        rst_n = 0; x_valid = 0; x_in = '0; w_we = 0; w_addr = '0; w_data = '0;
        b_we = 0; b_data = '0;
        repeat (3) tick();
        rst_n = 1;
        model_on = 1;
        #3;
        check("reset_sum_out", $signed(sum_out), 0);
        check("reset_sum_valid", {63'd0, sum_valid}, 0);
        check("reset_busy", {63'd0, busy}, 0);
        tick();

        // weights 3, bias 100, x = 2 x4 -> 124, latency 4
        set_all_w(3);
        write_b(100);
        fill_x(2);
        send_frame(0, -1);
        get_sum(v, t);
        check("basic_sum", v, 124);
        check("basic_latency", t - last_x, 4);
        drain();

        // overflow case
        set_all_w(16'h7FFF);
        write_b(0);
        fill_x(16'h7FFF);
        send_frame(0, -1);
        get_sum(v, t);
`ifdef NEURON_ACC_SAT_EN
        e = 32'sh7FFFFFFF;
`else
        e = 32'shFFFC0004;
`endif
        check("overflow_sum", v, e);
        drain();

        // back-to-back frames: +1s then -1s with weights 5
        set_all_w(5);
        fill_x(1);
        send_frame(0, -1);
        fill_x(-1);
        send_frame(0, -1);
        get_sum(v, t);
        check("b2b_first", v, 20);
        get_sum(v, t);
        check("b2b_second", v, -20);
        check("b2b_second_latency", t - last_x, 4);
        drain();

        // random gaps must give the same result as the gapless run
        for (int i = 0; i < N; i++) fx[i] = int'($urandom_range(0, 65535)) - 32768;
        send_frame(0, -1);
        get_sum(v_ref, t);
        drain();
        send_frame(3, -1);
        get_sum(v, t);
        check("gap_vs_gapless", v, v_ref);
        drain();

        // weight write mid-frame is dropped; after idle it lands
        set_all_w(5);
        fill_x(1);
        x_valid = 1; x_in = 16'd1; tick();
        x_valid = 1; x_in = 16'd1; tick();
        x_valid = 0;
        write_w(0, 7);
        x_valid = 1; x_in = 16'd1; tick();
        x_valid = 1; x_in = 16'd1; last_x = n; tick();
        x_valid = 0;
        get_sum(v, t);
        check("busy_write_dropped", v, 20);
        drain();
        write_w(0, 7);
        send_frame(0, -1);
        get_sum(v, t);
        check("idle_write_taken", v, 22);
        drain();

        // reset after 2 of 4 inputs: no sum, bias cleared
        write_b(50);
        send_frame(0, 2);
        drain();
        check("abort_no_sum", got_q.size(), 0);
        send_frame(0, -1);
        get_sum(v, t);
        check("after_reset_bias0", v, 22);
        drain();
        write_b(50);
        send_frame(0, -1);
        get_sum(v, t);
        check("bias_reloaded", v, 72);
        drain();

        // randomized traffic, checked cycle-by-cycle against the model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) write_w($urandom_range(0, N - 1), int'($urandom_range(0, 65535)));
            if ($urandom_range(0, 5) == 0) write_b(longint'($signed($urandom())));
            for (int i = 0; i < N; i++) fx[i] = int'($urandom_range(0, 65535)) - 32768;
            send_frame($urandom_range(0, 2), ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, N - 1)) : -1);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        got_q.delete();
        got_t.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
